adc_conv_sequencer: RTL
=======================

// Module: adc_conv_sequencer
// PURPOSE
//  Paces the sample-and-hold and ADC conversion cycle at a fixed sample period.
//  Each conversion runs track, hold plus start-of-conversion (SOC), wait for the
//  EOC rising edge, then capture. Channels are scanned round-robin through ch_sel.
//  Sits between the ADC/EOC interface and the output mux, and generates the
//  restart that NewStart-style EOC logic feeds on.
// PARAMETERS
//  DATA_W        8   ADC data width
//  NUM_CH        4   channels scanned, 1..2**CH_W
//  CH_W          2   channel index width
//  PERIOD        50  clk_in cycles between sample ticks, >= 2
//  TRACK_CYCLES  4   cycles sh_hold stays low (track) before SOC, >= 1
//  TIMEOUT       32  max WAIT_EOC cycles (only with SEQ_TIMEOUT_EN)
// PORTS
//  clk_in        in   1       system clock, all logic on rising edge
//  reset         in   1       synchronous, active-high
//  enable        in   1       1 = run sample ticks
//  EOC           in   1       ADC end-of-conversion; rising edge = data ready
//  adc_data      in   DATA_W  ADC result, valid while EOC high
//  sh_hold       out  1       0 = track, 1 = hold
//  soc           out  1       start-of-conversion, 1-cycle pulse
//  ch_sel        out  CH_W    mux channel for the current conversion
//  sample_data   out  DATA_W  last captured result
//  sample_ch     out  CH_W    channel of sample_data
//  sample_valid  out  1       1-cycle pulse when sample_data updates
//  busy          out  1       1 in any state other than IDLE
//  overrun       out  1       1-cycle pulse: a tick fell while busy
//  timeout       out  1       1-cycle pulse on EOC timeout (0 if macro off)
// BEHAVIOUR
//  Reset: state IDLE; period counter 0; channel 0; eoc_d 0. Every output 0.
//   Reset wins over all else. Reset mid-conversion drops it, with no valid pulse.
//  Period counter: held at 0 while enable=0. Else counts 0..PERIOD-1 and wraps.
//   tick = (cnt==PERIOD-1) & enable. First tick comes PERIOD cycles after enable rises.
//  eoc_d registers EOC every cycle. eoc_rise = EOC & ~eoc_d.
//  FSM (registered outputs, updated on the transition edge):
//   IDLE    : sh_hold=0. tick -> TRACK, ch_sel<=channel.
//   TRACK   : sh_hold=0 for TRACK_CYCLES cycles, then -> START.
//   START   : sh_hold=1, soc=1 for exactly 1 cycle -> WAIT_EOC.
//   WAIT_EOC: sh_hold=1, soc=0. eoc_rise -> CAPTURE.
//             An EOC already high on entry does not count; it needs a new 0->1.
//   CAPTURE : sample_data<=adc_data, sample_ch<=ch_sel, sample_valid=1 (1 cycle).
//             channel<=(channel==NUM_CH-1)?0:channel+1; sh_hold<=0; -> IDLE.
//  Latency: soc high TRACK_CYCLES+1 cycles after tick. sample_valid high 2 cycles
//   after the cycle EOC is first sampled high.
//  tick while busy: overrun=1 for 1 cycle. The tick is dropped (no queue).
//   The current conversion continues undisturbed.
//  enable falling mid-conversion: the conversion completes and no new tick follows.
//  sample_data/sample_ch hold their values between captures.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined:
//   WAIT_EOC counter starts at 0 on entry. On reaching TIMEOUT with no eoc_rise:
//   timeout=1 for 1 cycle, no capture, channel still advances, -> IDLE (sh_hold=0).
//   eoc_rise and timeout in the same cycle: eoc_rise wins.
//  SEQ_TIMEOUT_EN undefined: no counter. WAIT_EOC waits forever; timeout tied 0.
// TESTING (PERIOD=10, TRACK_CYCLES=3, NUM_CH=4, TIMEOUT=8)
//  1 reset 2 cycles, EOC=1 -> all outputs 0, ch_sel=0, busy=0, no soc.
//  2 enable=1; EOC rises 4 cycles after soc, adc_data=8'hA5 ->
//    soc 1 cycle at tick+4; sample_valid 1 cycle, sample_data=A5, sample_ch=0.
//  3 5 conversions, adc_data=ch*16 -> sample_ch 0,1,2,3,0; no overrun.
//  4 EOC held 1 before and after soc -> no capture; EOC 0 then 1 -> one capture.
//  5 EOC delayed 12 cycles after soc -> overrun pulse exactly once, no second soc;
//    reset asserted in WAIT_EOC -> IDLE next cycle, no sample_valid.
//  6 SEQ_TIMEOUT_EN, no EOC -> timeout pulse 8 cycles after START exit;
//    ch_sel=1 next conversion. Macro off -> busy stays 1, timeout stays 0.

Source files
------------

// File: rtl/adc_conv_sequencer.sv
// rtl/adc_conv_sequencer.sv - sample/hold + ADC conversion sequencer with round-robin channel scan
// Optional WAIT_EOC watchdog is compiled in when SEQ_TIMEOUT_EN is defined.
module adc_conv_sequencer #(
   parameter int DATA_W       = 8,
   parameter int NUM_CH       = 4,
   parameter int CH_W         = 2,
   parameter int PERIOD       = 50,
   parameter int TRACK_CYCLES = 4,
   parameter int TIMEOUT      = 32
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              enable,
   input  logic              EOC,
   input  logic [DATA_W-1:0] adc_data,
   output logic              sh_hold,
   output logic              soc,
   output logic [CH_W-1:0]   ch_sel,
   output logic [DATA_W-1:0] sample_data,
   output logic [CH_W-1:0]   sample_ch,
   output logic              sample_valid,
   output logic              busy,
   output logic              overrun,
   output logic              timeout
);

   localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int TRK_W = (TRACK_CYCLES > 1) ? $clog2(TRACK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
   localparam logic [TRK_W-1:0] TRK_LAST = TRK_W'(TRACK_CYCLES - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

   if (PERIOD < 2 || TRACK_CYCLES < 1 || TIMEOUT < 1 || NUM_CH < 1 || NUM_CH > 2**CH_W)
   begin : g_param_check
      $error("adc_conv_sequencer: illegal parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRACK,
      S_START,
      S_WAIT,
      S_CAPTURE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TRK_W-1:0]  trk_q, trk_d;
   logic [CH_W-1:0]   channel_q, channel_d;
   logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
   logic [CH_W-1:0]   sample_ch_q, sample_ch_d;
   logic [DATA_W-1:0] sample_data_q, sample_data_d;
   logic              sh_hold_q, sh_hold_d;
   logic              soc_q, soc_d;
   logic              sample_valid_q, sample_valid_d;
   logic              overrun_q, overrun_d;
   logic              eoc_q;
   logic              tick;
   logic              eoc_rise;
   logic [CH_W-1:0]   chan_next;

`ifdef SEQ_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   logic [TO_W-1:0] wcnt_q, wcnt_d;
   logic            timeout_q, timeout_d;
`endif

   assign tick      = (cnt_q == CNT_LAST) & enable;
   assign eoc_rise  = EOC & ~eoc_q;
   assign chan_next = (channel_q == CH_LAST) ? '0 : channel_q + 1'b1;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         trk_q          <= '0;
         channel_q      <= '0;
         ch_sel_q       <= '0;
         sample_ch_q    <= '0;
         sample_data_q  <= '0;
         sh_hold_q      <= 1'b0;
         soc_q          <= 1'b0;
         sample_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
         eoc_q          <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
         wcnt_q         <= '0;
         timeout_q      <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         trk_q          <= trk_d;
         channel_q      <= channel_d;
         ch_sel_q       <= ch_sel_d;
         sample_ch_q    <= sample_ch_d;
         sample_data_q  <= sample_data_d;
         sh_hold_q      <= sh_hold_d;
         soc_q          <= soc_d;
         sample_valid_q <= sample_valid_d;
         overrun_q      <= overrun_d;
         eoc_q          <= EOC;
`ifdef SEQ_TIMEOUT_EN
         wcnt_q         <= wcnt_d;
         timeout_q      <= timeout_d;
`endif
      end
   end

   always_comb begin
      state_d        = state_q;
      trk_d          = trk_q;
      channel_d      = channel_q;
      ch_sel_d       = ch_sel_q;
      sample_ch_d    = sample_ch_q;
      sample_data_d  = sample_data_q;
      sh_hold_d      = sh_hold_q;
      soc_d          = 1'b0;
      sample_valid_d = 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wcnt_d         = wcnt_q;
      timeout_d      = 1'b0;
`endif

      if (!enable)
         cnt_d = '0;
      else if (cnt_q == CNT_LAST)
         cnt_d = '0;
      else
         cnt_d = cnt_q + 1'b1;

      // A tick during a conversion is reported and dropped, never queued.
      overrun_d = tick & (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            sh_hold_d = 1'b0;
            if (tick) begin
               state_d  = S_TRACK;
               ch_sel_d = channel_q;
               trk_d    = '0;
            end
         end
         S_TRACK: begin
            if (trk_q == TRK_LAST) begin
               state_d   = S_START;
               sh_hold_d = 1'b1;
               soc_d     = 1'b1;
            end else begin
               trk_d = trk_q + 1'b1;
            end
         end
         S_START: begin
            state_d = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
            wcnt_d  = '0;
`endif
         end
         S_WAIT: begin
            // eoc_q is live through START, so an EOC already high needs a fresh 0->1.
            if (eoc_rise) begin
               state_d = S_CAPTURE;
            end
`ifdef SEQ_TIMEOUT_EN
            else if (wcnt_q == TO_LAST) begin
               state_d   = S_IDLE;
               timeout_d = 1'b1;
               channel_d = chan_next;
               sh_hold_d = 1'b0;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
`endif
         end
         S_CAPTURE: begin
            state_d        = S_IDLE;
            sample_data_d  = adc_data;
            sample_ch_d    = ch_sel_q;
            sample_valid_d = 1'b1;
            channel_d      = chan_next;
            sh_hold_d      = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign sh_hold      = sh_hold_q;
   assign soc          = soc_q;
   assign ch_sel       = ch_sel_q;
   assign sample_data  = sample_data_q;
   assign sample_ch    = sample_ch_q;
   assign sample_valid = sample_valid_q;
   assign busy         = (state_q != S_IDLE);
   assign overrun      = overrun_q;
`ifdef SEQ_TIMEOUT_EN
   assign timeout      = timeout_q;
`else
   assign timeout      = 1'b0;
`endif

endmodule
